// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EX/MEM/WB control FSM for the TSC 16-bit CPU (optional INST_COUNT_EN retire counter)
module multicycle_control #(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] instr,
  input  logic              mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic              i_or_d,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic [1:0]        pc_source,
  output logic              alu_mode,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              reg_write,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic              wwd_en,
  output logic              is_halted,
  output logic [CNT_W-1:0]  num_inst
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [3:0] OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_R = 4'd15;
  state_t state, next;
  logic   retire;
  logic [3:0] op;
  logic [5:0] func;
  logic is_r, is_br, is_lwd, is_swd, is_jmp, is_jal, is_jpr, is_jrl, is_wwd, is_hlt;
  logic unused_bits;
  assign op          = instr[15:12];
  assign func        = instr[5:0];
  assign unused_bits = ^instr[11:6];
  assign is_r   = op == OP_R;
  assign is_br  = op <= 4'd3;
  assign is_lwd = op == OP_LWD;
  assign is_swd = op == OP_SWD;
  assign is_jmp = op == OP_JMP;
  assign is_jal = op == OP_JAL;
  assign is_jpr = is_r && func == 6'd25;
  assign is_jrl = is_r && func == 6'd26;
  assign is_wwd = is_r && func == 6'd28;
  assign is_hlt = is_r && func == 6'd29;
  // Next-state and control outputs; everything forced low while reset is asserted
  always_comb begin
    next          = state;
    retire        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    alu_mode      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    reg_write     = 1'b0;
    reg_dst       = 2'd0;
    mem_to_reg    = 2'd0;
    wwd_en        = 1'b0;
    is_halted     = 1'b0;
    if (!reset) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'd1;
            next      = S_ID;
          end
        end
        S_ID: begin
          if (is_jmp || is_jal || is_jpr || is_jrl) begin
            pc_write   = 1'b1;
            pc_source  = (is_jpr || is_jrl) ? 2'd3 : 2'd2;
            reg_write  = is_jal || is_jrl;
            reg_dst    = (is_jal || is_jrl) ? 2'd2 : 2'd0;
            mem_to_reg = (is_jal || is_jrl) ? 2'd2 : 2'd0;
            retire     = 1'b1;
            next       = S_IF;
          end else if (is_wwd) begin
            wwd_en = 1'b1;
            retire = 1'b1;
            next   = S_IF;
          end else if (is_hlt) begin
            retire = 1'b1;
            next   = S_HALT;
          end else
            next = S_EX;
        end
        S_EX: begin
          if (is_br) begin
            alu_mode      = 1'b1;
            alu_src_a     = 1'b1;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
            retire        = 1'b1;
            next          = S_IF;
          end else if (is_r || op == OP_ADI || op == OP_ORI) begin
            alu_mode  = 1'b1;
            alu_src_a = 1'b1;
            alu_src_b = op == OP_ADI ? 2'd2 : op == OP_ORI ? 2'd3 : 2'd0;
            next      = S_WB;
          end else if (op == OP_LHI)
            next = S_WB;
          else if (is_lwd || is_swd) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            next      = S_MEM;
          end else begin
            retire = 1'b1;
            next   = S_IF;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_lwd;
          mem_write = is_swd;
          if (mem_ready) begin
            retire = is_swd;
            next   = is_lwd ? S_WB : S_IF;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_r ? 2'd1 : 2'd0;
          mem_to_reg = is_lwd ? 2'd1 : op == OP_LHI ? 2'd3 : 2'd0;
          retire     = 1'b1;
          next       = S_IF;
        end
        S_HALT: is_halted = 1'b1;
        default: next = S_IF;
      endcase
    end
  end
  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= next;
  end
`ifdef INST_COUNT_EN
  logic [CNT_W-1:0] cnt;
  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)       cnt <= '0;
    else if (retire) cnt <= cnt + 1'b1;
  end
  assign num_inst = cnt;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign num_inst      = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed-vector bench for multicycle_control
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [15:0] instr;
  logic mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic alu_mode, alu_src_a, reg_write, wwd_en, is_halted;
  logic [3:0] num_inst;
  logic [18:0] ctl;
  int n_cmp = 0, n_err = 0, wwd_cnt = 0, exp_cnt = 0;
  multicycle_control #(.WORD_W(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .alu_mode(alu_mode), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .wwd_en(wwd_en), .is_halted(is_halted), .num_inst(num_inst)
  );
  always #5 clk = ~clk;
  assign ctl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                alu_mode, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, wwd_en, is_halted};
  always @(negedge clk) if (wwd_en === 1'b1) wwd_cnt++;
  function automatic logic [18:0] mk(input logic mr, mw, iod, irw, pcw, pcc, input logic [1:0] ps,
                                     input logic am, asa, input logic [1:0] asb, input logic rw,
                                     input logic [1:0] rd, m2r, input logic ww, h);
    return {mr, mw, iod, irw, pcw, pcc, ps, am, asa, asb, rw, rd, m2r, ww, h};
  endfunction
  function automatic logic [3:0] exp_num(input int c);
`ifdef INST_COUNT_EN
    return 4'(c % 16);
`else
    return 4'(c * 0);
`endif
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [18:0] exp);
    @(negedge clk);
    check(tag, {13'd0, ctl}, {13'd0, exp});
    @(posedge clk);
    #1;
  endtask
  logic [18:0] IF_RDY, IF_WAIT, ZERO, EX_ADI, WB_I, EX_MEM, MEM_RD, MEM_WR, WB_LW, EX_BR;
  logic [18:0] ID_JAL, EX_R, WB_R, ID_JPR, WB_LHI, ID_WWD, HALT;
  initial begin
    IF_RDY  = mk(1,0,0,1,1,0,2'd0,0,0,2'd1,0,2'd0,2'd0,0,0);
    IF_WAIT = mk(1,0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,0,0);
    ZERO    = '0;
    EX_ADI  = mk(0,0,0,0,0,0,2'd0,1,1,2'd2,0,2'd0,2'd0,0,0);
    WB_I    = mk(0,0,0,0,0,0,2'd0,0,0,2'd0,1,2'd0,2'd0,0,0);
    EX_MEM  = mk(0,0,0,0,0,0,2'd0,0,1,2'd2,0,2'd0,2'd0,0,0);
    MEM_RD  = mk(1,0,1,0,0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,0,0);
    MEM_WR  = mk(0,1,1,0,0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,0,0);
    WB_LW   = mk(0,0,0,0,0,0,2'd0,0,0,2'd0,1,2'd0,2'd1,0,0);
    EX_BR   = mk(0,0,0,0,0,1,2'd1,1,1,2'd0,0,2'd0,2'd0,0,0);
    ID_JAL  = mk(0,0,0,0,1,0,2'd2,0,0,2'd0,1,2'd2,2'd2,0,0);
    EX_R    = mk(0,0,0,0,0,0,2'd0,1,1,2'd0,0,2'd0,2'd0,0,0);
    WB_R    = mk(0,0,0,0,0,0,2'd0,0,0,2'd0,1,2'd1,2'd0,0,0);
    ID_JPR  = mk(0,0,0,0,1,0,2'd3,0,0,2'd0,0,2'd0,2'd0,0,0);
    WB_LHI  = mk(0,0,0,0,0,0,2'd0,0,0,2'd0,1,2'd0,2'd3,0,0);
    ID_WWD  = mk(0,0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,1,0);
    HALT    = mk(0,0,0,0,0,0,2'd0,0,0,2'd0,0,2'd0,2'd0,0,1);
    reset = 1'b1; mem_ready = 1'b1; instr = 16'h4105;
    repeat (3) step("reset_outputs", ZERO);
    check("num_after_reset", 32'(num_inst), 32'd0);
    reset = 1'b0;
    step("adi_if", IF_RDY); step("adi_id", ZERO); step("adi_ex", EX_ADI); step("adi_wb", WB_I);
    exp_cnt++; check("num_adi", 32'(num_inst), 32'(exp_num(exp_cnt)));
    instr = 16'h7105;
    step("lwd_if", IF_RDY); step("lwd_id", ZERO); step("lwd_ex", EX_MEM);
    mem_ready = 1'b0;
    repeat (3) step("lwd_mem_wait", MEM_RD);
    mem_ready = 1'b1;
    step("lwd_mem_done", MEM_RD); step("lwd_wb", WB_LW); exp_cnt++;
    instr = 16'h1203; mem_ready = 1'b0;
    step("beq_if_wait", IF_WAIT);
    mem_ready = 1'b1;
    step("beq_if", IF_RDY); step("beq_id", ZERO); step("beq_ex", EX_BR); exp_cnt++;
    instr = 16'hA123;
    step("jal_if", IF_RDY); step("jal_id", ID_JAL); exp_cnt++;
    instr = 16'h8105;
    step("swd_if", IF_RDY); step("swd_id", ZERO); step("swd_ex", EX_MEM); step("swd_mem", MEM_WR); exp_cnt++;
    instr = 16'hF040;
    step("add_if", IF_RDY); step("add_id", ZERO); step("add_ex", EX_R); step("add_wb", WB_R); exp_cnt++;
    instr = 16'hF019;
    step("jpr_if", IF_RDY); step("jpr_id", ID_JPR); exp_cnt++;
    instr = 16'h6012;
    step("lhi_if", IF_RDY); step("lhi_id", ZERO); step("lhi_ex", ZERO); step("lhi_wb", WB_LHI); exp_cnt++;
    check("num_mix", 32'(num_inst), 32'(exp_num(exp_cnt)));
    instr = 16'h7105;
    step("abort_if", IF_RDY); step("abort_id", ZERO); step("abort_ex", EX_MEM);
    mem_ready = 1'b0;
    step("abort_mem", MEM_RD);
    reset = 1'b1;
    step("abort_reset", ZERO);
    reset = 1'b0; mem_ready = 1'b1; exp_cnt = 0;
    check("num_abort", 32'(num_inst), 32'd0);
    instr = 16'hF01C;
    for (int i = 0; i < 17; i++) begin
      step("wwd_if", IF_RDY); step("wwd_id", ID_WWD); exp_cnt++;
    end
    check("wwd_pulses", 32'(wwd_cnt), 32'd17);
    check("num_wwd_wrap", 32'(num_inst), 32'(exp_num(exp_cnt)));
    instr = 16'hF01D;
    step("hlt_if", IF_RDY); step("hlt_id", ZERO); exp_cnt++;
    instr = 16'h4105;
    repeat (4) step("halted", HALT);
    check("num_halt", 32'(num_inst), 32'(exp_num(exp_cnt)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
